// File: rtl/d1_pe_param_if.sv
// d1_pe_param_if: frame start, sample stream, weight write port and result handshake for d1_pe_param
interface d1_pe_param_if #(parameter int DW = 8, WW = 8, K = 5, AW = 16, CW = $clog2(K));
    logic start;
    logic [DW-1:0] in_data;
    logic in_valid;
    logic in_ready;
    logic w_we;
    logic [CW-1:0] w_addr;
    logic [WW-1:0] w_data;
    logic busy;
    logic [K*AW-1:0] y;
    logic out_valid;
    logic out_ready;
    modport master(output start, in_data, in_valid, w_we, w_addr, w_data, out_ready,
                   input in_ready, busy, y, out_valid);
    modport slave(input start, in_data, in_valid, w_we, w_addr, w_data, out_ready,
                  output in_ready, busy, y, out_valid);
endinterface

// File: rtl/d1_pe_param.sv
// d1_pe_param: K-tap 1-D correlation PE, y_i = sum_k W[k]*x[i+k], with weight bank and valid/ready handshake.
// Define D1_PE_SAT_EN for accumulators that saturate at 2^AW-1; otherwise they wrap modulo 2^AW.
module d1_pe_param #(parameter int DW = 8, WW = 8, K = 5, AW = 16, CW = $clog2(K)) (
    input logic clk,
    input logic reset,
    d1_pe_param_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FILL, MAC, DONE} state_t;
    state_t state, state_nx;
    logic [DW-1:0] r [K];
    logic [WW-1:0] w [K];
    logic [AW-1:0] acc [K];
    logic [AW-1:0] acc_nx [K];
    logic [DW+WW-1:0] prod [K];
`ifdef D1_PE_SAT_EN
    logic [K-1:0] ovf;
`endif
    logic [CW-1:0] cnt;
    logic last, take, fire;
    assign last = cnt == CW'(K - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        bus.in_ready = state == FILL || (state == MAC && !last);
        bus.busy = state != IDLE;
        bus.out_valid = state == DONE;
        take = bus.in_valid && bus.in_ready;
        fire = state == MAC && (last || bus.in_valid);
        state_nx = state;
        case (state)
            IDLE: state_nx = bus.start ? FILL : IDLE;
            FILL: state_nx = take && last ? MAC : FILL;
            MAC: state_nx = fire && last ? DONE : MAC;
            DONE: state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // Every channel uses the same weight W[cnt] against its own pre-shift sample.
    always_comb
        for (int i = 0; i < K; i++) begin
            prod[i] = {{WW{1'b0}}, r[i]} * {{DW{1'b0}}, w[cnt]};
`ifdef D1_PE_SAT_EN
            {ovf[i], acc_nx[i]} = {1'b0, acc[i]} + {1'b0, AW'(prod[i])};
            if (ovf[i]) acc_nx[i] = '1;
`else
            acc_nx[i] = acc[i] + AW'(prod[i]);
`endif
        end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt <= '0;
            for (int i = 0; i < K; i++) begin
                r[i] <= '0;
                w[i] <= '0;
                acc[i] <= '0;
            end
        end else begin
            if (state == IDLE && bus.start) begin
                cnt <= '0;
                for (int i = 0; i < K; i++) acc[i] <= '0;
            end
            if (take) begin
                for (int i = 0; i < K - 1; i++) r[i] <= r[i+1];
                r[K-1] <= bus.in_data;
            end
            if ((state == FILL && take) || fire) cnt <= last ? '0 : cnt + CW'(1);
            if (fire)
                for (int i = 0; i < K; i++) acc[i] <= acc_nx[i];
            if ((state == IDLE || state == DONE) && bus.w_we && 32'(bus.w_addr) < K)
                w[bus.w_addr] <= bus.w_data;
        end
    for (genvar i = 0; i < K; i++) assign bus.y[i*AW +: AW] = acc[i];
endmodule

// File: tb/tb_d1_pe_param.sv
// tb_d1_pe_param: randomized self-checking bench for d1_pe_param against a frame-level correlation model.
module tb_d1_pe_param;
    localparam int DW = 8, WW = 8, K = 5, AW = 16, CW = $clog2(K), N = 2 * K - 1;
    localparam longint YMAX = (longint'(1) << AW) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    d1_pe_param_if #(.DW(DW), .WW(WW), .K(K), .AW(AW), .CW(CW)) bus();
    d1_pe_param #(.DW(DW), .WW(WW), .K(K), .AW(AW), .CW(CW)) dut(.clk(clk), .reset(reset), .bus(bus));
    int total = 0, bad = 0;
    logic [DW-1:0] xs [N];
    logic [WW-1:0] wm [K];
    int n_acc, lat;
    logic [K*AW-1:0] ycap;

    // Direct correlation over the whole frame; per-add saturation equals clamping the sum since products are non-negative.
    function automatic logic [AW-1:0] model_y(input int i);
        longint s = 0;
        for (int k = 0; k < K; k++) s += (longint'(wm[k]) * longint'(xs[i+k])) & YMAX;
`ifdef D1_PE_SAT_EN
        return AW'(s > YMAX ? YMAX : s);
`else
        return AW'(s & YMAX);
`endif
    endfunction

    function automatic logic [K*AW-1:0] model_all();
        logic [K*AW-1:0] v;
        for (int i = 0; i < K; i++) v[i*AW +: AW] = model_y(i);
        return v;
    endfunction

    task automatic load_w();
        for (int k = 0; k < K; k++) begin
            bus.w_we = 1'b1; bus.w_addr = CW'(k); bus.w_data = wm[k];
            @(negedge clk);
        end
        for (int a = K; a < (1 << CW); a++) begin
            bus.w_we = 1'b1; bus.w_addr = CW'(a); bus.w_data = WW'($urandom);
            @(negedge clk);
        end
        bus.w_we = 1'b0;
    endtask

    // mode 0: in_valid held high, 1: toggled each cycle, 2: random; noise adds start/w_we pulses during the frame
    task automatic run_frame(input int mode, input bit noise);
        int cyc = 0, first = -1;
        n_acc = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.out_valid !== 1'b1 && cyc < 500) begin
            bus.in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(1, 0));
            bus.in_data = n_acc < N ? xs[n_acc] : DW'($urandom);
            if (noise) begin
                bus.start = 1'($urandom_range(1, 0));
                bus.w_we = 1'($urandom_range(1, 0));
                bus.w_addr = '0;
                bus.w_data = 8'd9;
            end
            if (bus.in_valid && bus.in_ready) begin
                if (first < 0) first = cyc;
                n_acc++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0; bus.start = 1'b0; bus.w_we = 1'b0;
        lat = bus.out_valid === 1'b1 ? cyc - first + 1 : -1;
        ycap = bus.y;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (bus.y !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_init y=%0h ov=%b busy=%b ir=%b want all 0", bus.y, bus.out_valid, bus.busy, bus.in_ready);
        end
        reset = 1'b0;
        for (int k = 0; k < K; k++) wm[k] = WW'(k + 1);
        for (int n = 0; n < N; n++) xs[n] = DW'(n + 1);
        load_w();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int n = 0; n < K + 2; n++) begin
            bus.in_data = xs[n];
            @(negedge clk);
        end
        total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_mac busy=%b ir=%b want 1 1", bus.busy, bus.in_ready);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (bus.y !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_mid_mac y=%0h ov=%b busy=%b ir=%b want all 0", bus.y, bus.out_valid, bus.busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_abort ov=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
        for (int k = 0; k < K; k++) wm[k] = '0;
        run_frame(0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || ycap !== model_all()) begin
            bad++; $display("FAIL reset_weights_zero ov=%b y=%0h want ov=1 y=%0h", bus.out_valid, ycap, model_all());
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_basic();
        for (int k = 0; k < K; k++) wm[k] = WW'(k + 1);
        for (int n = 0; n < N; n++) xs[n] = DW'(n + 1);
        load_w();
        run_frame(0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.out_valid); end
        for (int i = 0; i < K; i++) begin
            total++;
            if (ycap[i*AW +: AW] !== model_y(i)) begin
                bad++; $display("FAIL basic_y%0d got=%0d want=%0d", i, ycap[i*AW +: AW], model_y(i));
            end
        end
        total++;
        if (ycap[0 +: AW] !== 16'd55 || ycap[(K-1)*AW +: AW] !== 16'd115) begin
            bad++; $display("FAIL basic_const y0=%0d y4=%0d want 55 115", ycap[0 +: AW], ycap[(K-1)*AW +: AW]);
        end
        total++;
        if (n_acc !== N) begin bad++; $display("FAIL basic_count got=%0d want=%0d", n_acc, N); end
        total++;
        if (lat !== 2 * K + 1) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", lat, 2 * K + 1); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        total++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL basic_release ov=%b busy=%b want 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < K; k++) wm[k] = WW'(k + 1);
        for (int n = 0; n < N; n++) xs[n] = DW'(n + 1);
        run_frame(1, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || ycap !== model_all()) begin
            bad++; $display("FAIL stall_y ov=%b y=%0h want ov=1 y=%0h", bus.out_valid, ycap, model_all());
        end
        total++;
        if (n_acc !== N) begin bad++; $display("FAIL stall_count got=%0d want=%0d", n_acc, N); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.y !== model_all()) begin
                bad++; $display("FAIL hold_c%0d ov=%b busy=%b y=%0h want 1 1 %0h", c, bus.out_valid, bus.busy, bus.y, model_all());
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_ignored();
        for (int k = 0; k < K; k++) wm[k] = WW'(k + 1);
        for (int n = 0; n < N; n++) xs[n] = DW'(n + 1);
        run_frame(0, 1'b1);
        total++;
        if (bus.out_valid !== 1'b1 || ycap !== model_all()) begin
            bad++; $display("FAIL ignored_y ov=%b y=%0h want ov=1 y=%0h", bus.out_valid, ycap, model_all());
        end
        total++;
        if (n_acc !== N) begin bad++; $display("FAIL ignored_count got=%0d want=%0d", n_acc, N); end
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL start_in_done busy=%b ov=%b want 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < K; k++) wm[k] = '1;
        for (int n = 0; n < N; n++) xs[n] = '1;
        load_w();
        run_frame(2, 1'b0);
        for (int i = 0; i < K; i++) begin
            total++;
            if (ycap[i*AW +: AW] !== model_y(i)) begin
                bad++; $display("FAIL ovf_y%0d got=%0d want=%0d", i, ycap[i*AW +: AW], model_y(i));
            end
        end
        total++;
`ifdef D1_PE_SAT_EN
        if (ycap[0 +: AW] !== 16'd65535) begin bad++; $display("FAIL ovf_const got=%0d want=65535", ycap[0 +: AW]); end
`else
        if (ycap[0 +: AW] !== 16'd62981) begin bad++; $display("FAIL ovf_const got=%0d want=62981", ycap[0 +: AW]); end
`endif
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < K; k++) wm[k] = WW'(k + 1);
        for (int n = 0; n < N; n++) xs[n] = DW'($urandom);
        load_w();
        run_frame(2, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || ycap !== model_all()) begin
            bad++; $display("FAIL b2b_first y=%0h want %0h", ycap, model_all());
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int n = 0; n < N; n++) xs[n] = DW'(n + 1);
        run_frame(0, 1'b0);
        total++;
        if (bus.out_valid !== 1'b1 || ycap !== model_all() || lat !== 2 * K + 1) begin
            bad++; $display("FAIL b2b_second y=%0h lat=%0d want %0h %0d", ycap, lat, model_all(), 2 * K + 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < K; k++) wm[k] = WW'($urandom);
            for (int n = 0; n < N; n++) xs[n] = DW'($urandom);
            load_w();
            run_frame(2, f[0]);
            total++;
            if (bus.out_valid !== 1'b1 || ycap !== model_all() || n_acc !== N) begin
                bad++; $display("FAIL random_f%0d y=%0h n=%0d want %0h %0d", f, ycap, n_acc, model_all(), N);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.in_data = '0; bus.in_valid = 1'b0; bus.w_we = 1'b0;
        bus.w_addr = '0; bus.w_data = '0; bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_ignored();
        test_overflow();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/d1_pe_param.md
Name: d1_pe_param

Overview:
- Parametrised successor to the fixed 5-tap 1-D convolution PE.
- Computes one frame of K correlation outputs y_i = sum_k W[k]*x[i+k], for i,k = 0..K-1, from a 2K-1 sample stream.
- Holds weights in an internal writable bank instead of a muxed external bus; adds a start/valid/ready handshake so it can drop into the streaming datapath between the sample buffer and the output collector.

Parameters:
- DW, 8: sample width, unsigned.
- WW, 8: weight width, unsigned.
- K, 5: tap count and output count (2..16).
- AW, 16: accumulator and output width per channel.
- CW, $clog2(K): width of the weight address and step counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start; honoured only in IDLE.
- in_data  in  DW  sample.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accepted when in_valid & in_ready.
- w_we  in  1  weight write strobe.
- w_addr  in  CW  weight index.
- w_data  in  WW  weight value.
- busy  out  1  high in any state other than IDLE.
- y  out  K*AW  packed results; y_i occupies bits [i*AW +: AW].
- out_valid  out  1  results valid.
- out_ready  in  1  consumer accepts results.

Behaviour:
- Reset: all of the following are cleared and the FSM goes to IDLE. Outputs are 0 during reset.
  - Sample regs R[0..K-1], weights W[0..K-1], accumulators, counters.
  - y, out_valid, in_ready, busy.
  - Reset asserted mid-frame aborts the frame; no partial out_valid.
- Weight writes:
  - W[w_addr] <= w_data when w_we is high in IDLE or DONE.
  - Ignored in FILL/MAC.
  - w_addr >= K is ignored.
- FSM states: IDLE, FILL, MAC, DONE.
- IDLE:
  - in_ready = 0.
  - On start: clear all accumulators, counter = 0, go to FILL.
- FILL:
  - in_ready = 1.
  - Each accepted sample shifts: R[K-1] <= in_data, R[j] <= R[j+1]. R[0] is the oldest.
  - After the K-th accepted sample go to MAC, step counter k = 0.
- MAC step k:
  - Every channel updates acc_i <= acc_i + W[k]*R[i], using pre-shift R values.
  - Product width is DW+WW. It is zero-extended or truncated to AW before the add.
  - Steps k = 0..K-2: in_ready = 1; the step fires only on in_valid & in_ready. The same accepted sample shifts into R in that same cycle.
  - Step K-1: in_ready = 0; fires unconditionally, no sample consumed. Go to DONE.
  - No in_valid means stall: accumulators, R and k hold.
  - Total samples consumed per frame: 2K-1.
- DONE:
  - out_valid = 1 and y = accumulators, both stable until out_ready.
  - out_valid rises the cycle after step K-1.
  - When out_valid & out_ready: out_valid drops next cycle, go to IDLE.
  - A start arriving in the same cycle as out_ready is ignored; start is only honoured in IDLE.
- start outside IDLE: ignored.
- Arithmetic: unsigned only. Overflow behaviour is set by the optional feature below.
- Minimum frame latency with in_valid held high: K fill cycles + K MAC cycles, then out_valid on the next edge.

Optional Feature:
- Macro D1_PE_SAT_EN.
- Defined: each accumulate saturates at 2^AW-1. Once saturated, a channel stays at 2^AW-1 for the rest of the frame.
- Undefined: accumulate wraps modulo 2^AW.
- No port or timing difference between the two builds.

Test Plan:
- Reset and weight load:
  - Assert reset mid-MAC -> y = 0, out_valid = 0, busy = 0, in_ready = 0 on that edge.
  - After release, W reads as 0: a frame of samples 1..9 gives y = 0 on all channels.
- Basic frame, K=5:
  - Stimulus: W = {1,2,3,4,5}, start, then samples 1..9 with in_valid held high.
  - Expected: y0..y4 = 55, 70, 85, 100, 115.
  - Exactly 9 samples accepted; out_valid rises 11 cycles after the first accepted sample.
- Back-pressure and stall:
  - Same frame with in_valid toggled 1/0 each cycle -> same y values, no sample lost or duplicated.
  - out_ready held low 10 cycles -> y and out_valid stay stable; busy = 1 throughout.
- Ignored controls:
  - start pulses during FILL/MAC -> no restart.
  - w_we during MAC (addr 0, data 9) -> W[0] unchanged; the frame still yields 55..115.
- Overflow:
  - Stimulus: W all 255, samples all 255, AW=16.
  - Without D1_PE_SAT_EN -> each y_i = 62981 (325125 mod 65536).
  - With D1_PE_SAT_EN -> each y_i = 65535.
- Back-to-back frames:
  - out_ready and start in consecutive cycles -> the second frame runs cleanly.
  - Accumulators cleared: frame 2 with samples 1..9 repeats 55..115 with no carry-over.
